onchip_mem_arbiter: RTL and testbench

Two-requester round-robin arbiter in front of the single-port 32-bit on-chip RAM (32000 words, 15-bit word address, 4 byte lanes). It presents two Avalon-MM slave ports with waitrequest and pipelined readdatavalid, issues at most one command per clock to the RAM, and routes read data back to the issuing requester. The RAM has registered address and unregistered output, so its read latency is exactly 1 cycle.

---
 rtl/onchip_mem_pkg.sv | 18 +
 rtl/rr_hold_arbiter.sv | 72 +++++++
 rtl/onchip_mem_arbiter.sv | 105 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared constants and types for the on-chip RAM arbiter
// slice.
//   ADDR_W_DEF   - default word address width of the RAM and requester ports
//   DATA_W_DEF   - default data width (byteenable width is DATA_W/8)
//   MAX_HOLD_DEF - default number of back-to-back accepts one requester may
//                  take while the other requester is waiting
//   HOLD_W       - width of the hold counter (covers MAX_HOLD 1..15)
//   req_id_t     - requester identifier (0 or 1)
package onchip_mem_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_HOLD_DEF = 4;
  localparam int HOLD_W       = 4;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: two-way round-robin arbiter with a bounded hold.
// The current owner keeps the grant under contention until it has taken
// MAX_HOLD consecutive accepts, then the grant passes to the other side.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   req_i    - request vector, bit i = requester i
//   grant_o  - combinational grant (0 when nobody requests)
//   accept_o - a command is accepted this cycle
import onchip_mem_pkg::*;

module rr_hold_arbiter #(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output req_id_t    grant_o,
  output logic       accept_o
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  req_id_t           last_grant_q, last_grant_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // A hold count of zero means the previous cycle had no accept, so there is
  // no owner to keep; contention then goes to the side opposite last_grant.
  // With last_grant resetting to 1 this makes requester 0 win the first
  // contention after reset.
  always_comb begin
    grant_o = 1'b0;
    unique case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11: begin
        if ((hold_cnt_q != '0) && (hold_cnt_q < MAX_HOLD_C))
          grant_o = last_grant_q;
        else
          grant_o = ~last_grant_q;
      end
      default: grant_o = 1'b0;
    endcase
  end

  // Whenever anyone requests, the grant lands on a requester, so there is
  // always an accept.
  assign accept_o = |req_i;

  always_comb begin
    last_grant_d = last_grant_q;
    hold_cnt_d   = '0;
    if (accept_o) begin
      last_grant_d = grant_o;
      if (grant_o == last_grant_q)
        hold_cnt_d = (hold_cnt_q < MAX_HOLD_C) ? hold_cnt_q + 1'b1 : hold_cnt_q;
      else
        hold_cnt_d = HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM between two
// Avalon-MM requesters. At most one command per clock is passed to the RAM;
// read data (1-cycle RAM latency) is steered back by a one-entry tag pipe.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   m0_* / m1_*           - requester slave ports (address, byteenable, read,
//                           write, writedata, waitrequest, readdata,
//                           readdatavalid)
//   mem_*                 - RAM master side (address, byteenable, chipselect,
//                           write, writedata, clken, readdata)
import onchip_mem_pkg::*;

module onchip_mem_arbiter #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req;
  req_id_t    grant;
  logic       accept;
  req_id_t    sel;
  logic       wr_sel;
  logic       rd_accept;

  logic       rd_pend_q, rd_pend_d;
  req_id_t    rd_tag_q, rd_tag_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_hold_arbiter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .req_i    (req),
    .grant_o  (grant),
    .accept_o (accept)
  );

  assign m0_waitrequest = ~((grant == 1'b0) & req[0]);
  assign m1_waitrequest = ~((grant == 1'b1) & req[1]);

  // Idle cycles park the mux on requester 0.
  assign sel = accept & grant;

  assign mem_address    = sel ? m1_address    : m0_address;
  assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
  assign wr_sel         = sel ? m1_write      : m0_write;

  assign mem_chipselect = accept;
  assign mem_write      = accept & wr_sel;
  assign mem_clken      = 1'b1;

  // Read with write also high is handled as a write, so it never returns data.
  assign rd_accept = accept & ~wr_sel;

  always_comb begin
    rd_pend_d = rd_accept;
    rd_tag_d  = rd_accept ? sel : rd_tag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign m0_readdatavalid = rd_pend_q & (rd_tag_q == 1'b0);
  assign m1_readdatavalid = rd_pend_q & (rd_tag_q == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Testbench for onchip_mem_arbiter with a behavioural RAM (registered
// address, unregistered data out). Expected read returns are queued when a
// read is expected to be accepted and compared when they fall due.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Behavioural RAM: full 15-bit space so out-of-range addresses are safe.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_addr_q;
  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
    ram_addr_q = '0;
  end
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Bench-side shadow of RAM contents, used only to form expectations.
  logic [31:0] shadow [int];

  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] shadow_rd(input logic [14:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
  endfunction

  function automatic void shadow_wr(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = shadow_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    shadow[int'(a)] = v;
  endfunction

  // Read-return monitor, evaluated at the sampling point of every cycle.
  task automatic check_returns();
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rdv0", 64'(m0_readdatavalid), 64'(e.tag == 1'b0));
      check("rdv1", 64'(m1_readdatavalid), 64'(e.tag == 1'b1));
      check("rdata", 64'(e.tag ? m1_readdata : m0_readdata), 64'(e.data));
      $display("cyc=%0d return tag=%0d data=0x%08h", cyc, e.tag, e.tag ? m1_readdata : m0_readdata);
    end else begin
      check("rdv0_idle", 64'(m0_readdatavalid), 64'd0);
      check("rdv1_idle", 64'(m1_readdatavalid), 64'd0);
    end
  endtask

  // One bus cycle: drive both ports, check accepts and mem strobes at the
  // falling edge, queue expected read returns, advance past the rising edge.
  task automatic do_cycle(
    input logic r0, input logic w0, input logic [14:0] a0, input logic [3:0] be0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [14:0] a1, input logic [3:0] be1, input logic [31:0] d1,
    input logic e0, input logic e1);
    exp_t e;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    @(negedge clk);
    check_returns();
    check("wait0", 64'(m0_waitrequest), 64'(!e0));
    check("wait1", 64'(m1_waitrequest), 64'(!e1));
    check("mem_cs", 64'(mem_chipselect), 64'(e0 | e1));
    check("mem_wr", 64'(mem_write), 64'((e0 & w0) | (e1 & w1)));
    $display("cyc=%0d m0(r%0d w%0d a=%04h) m1(r%0d w%0d a=%04h) wait0=%0d wait1=%0d cs=%0d wr=%0d",
             cyc, r0, w0, a0, r1, w1, a1, m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write);
    if (e0) begin
      if (w0) shadow_wr(a0, be0, d0);
      else if (r0) begin e.tag = 1'b0; e.data = shadow_rd(a0); e.due = cyc + 1; sb.push_back(e); end
    end
    if (e1) begin
      if (w1) shadow_wr(a1, be1, d1);
      else if (r1) begin e.tag = 1'b1; e.data = shadow_rd(a1); e.due = cyc + 1; sb.push_back(e); end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    do_cycle(0, 0, 15'h0, 4'h0, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0, 0, 0);
  endtask

  // Reset asserted for one cycle; any return in flight is dropped.
  task automatic do_reset();
    reset_n = 1'b0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    @(negedge clk);
    check("rst_rdv0", 64'(m0_readdatavalid), 64'd0);
    check("rst_rdv1", 64'(m1_readdatavalid), 64'd0);
    check("rst_cs", 64'(mem_chipselect), 64'd0);
    check("rst_wr", 64'(mem_write), 64'd0);
    check("rst_wait0", 64'(m0_waitrequest), 64'd1);
    check("rst_wait1", 64'(m1_waitrequest), 64'd1);
    check("rst_clken", 64'(mem_clken), 64'd1);
    $display("cyc=%0d reset rdv0=%0d rdv1=%0d cs=%0d", cyc, m0_readdatavalid, m1_readdatavalid, mem_chipselect);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc++;
  endtask

  initial begin
    logic first0;
    do_reset();
    idle();

    // Write then read back on m0.
    do_cycle(0, 1, 15'h0010, 4'hF, 32'hDEADBEEF, 0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    do_cycle(1, 0, 15'h0010, 4'hF, 32'h0,        0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    idle();
    idle();

    // Byte-lane merge: 0x11223344 then 0xAABBCCDD on lanes 0 and 2.
    do_cycle(0, 1, 15'h0020, 4'hF, 32'h11223344, 0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    do_cycle(0, 1, 15'h0020, 4'h5, 32'hAABBCCDD, 0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    check("merge_model", 64'(shadow_rd(15'h0020)), 64'h11BB33DD);
    do_cycle(1, 0, 15'h0020, 4'hF, 32'h0,        0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    idle();

    // Continuous contention from reset: m0 x4, m1 x4, ...
    do_reset();
    for (int k = 0; k < 16; k++) begin
      first0 = ((k / 4) % 2) == 0;
      do_cycle(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0, first0, !first0);
    end
    idle();

    // Alternating single requests: no waits, no bubbles.
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 0, 15'h0010, 4'hF, 32'h0, 0, 0, 15'h0,    4'h0, 32'h0, 1, 0);
      do_cycle(0, 0, 15'h0,    4'h0, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0, 0, 1);
    end
    idle();

    // Reset the cycle after an m1 read accept: its return is dropped, and
    // the first contention afterwards goes to m0.
    do_cycle(0, 0, 15'h0, 4'h0, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0, 0, 1);
    do_reset();
    do_cycle(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0, 1, 0);
    idle();

    // Read and write together on m0 act as a write only.
    do_cycle(1, 1, 15'h7FFF, 4'hF, 32'hCAFEF00D, 0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    idle();
    do_cycle(1, 0, 15'h7FFF, 4'hF, 32'h0,        0, 0, 15'h0, 4'h0, 32'h0, 1, 0);
    idle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
